// File: rtl/cache_stats.sv
// Cache hit/miss statistics: saturating live counters, snapshot on print, per-mille ratios via a
// 42-cycle restoring divider per cache, then a 9-word valid/ready report held stable under backpressure.
module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  n,
  input  logic        ins_hit,
  input  logic        ins_miss,
  input  logic        dat_hit,
  input  logic        dat_miss,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [3:0]  rpt_sel,
  output logic [31:0] rpt_data,
  output logic        rpt_last,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIV_I, DIV_D, SEND} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        rpt_valid_q, rpt_valid_d;
  logic [3:0]  rpt_sel_q, rpt_sel_d;
  logic [31:0] rpt_data_q, rpt_data_d;
  logic        rpt_last_q, rpt_last_d;

  logic [31:0] ins_reads_q, ins_reads_d, dat_reads_q, dat_reads_d, dat_writes_q, dat_writes_d;
  logic [31:0] ins_hits_q, ins_hits_d, ins_misses_q, ins_misses_d;
  logic [31:0] dat_hits_q, dat_hits_d, dat_misses_q, dat_misses_d;

  logic [31:0] snap_ins_reads_q, snap_ins_reads_d, snap_dat_reads_q, snap_dat_reads_d;
  logic [31:0] snap_dat_writes_q, snap_dat_writes_d, snap_ins_hits_q, snap_ins_hits_d;
  logic [31:0] snap_ins_misses_q, snap_ins_misses_d, snap_dat_hits_q, snap_dat_hits_d;
  logic [31:0] snap_dat_misses_q, snap_dat_misses_d;
  logic [9:0]  ins_ratio_q, ins_ratio_d, dat_ratio_q, dat_ratio_d;

  logic [41:0] div_num_q, div_num_d;
  logic [32:0] div_den_q, div_den_d;
  logic [32:0] div_rem_q, div_rem_d;
  logic [8:0]  div_quo_q, div_quo_d;
  logic [5:0]  div_cnt_q, div_cnt_d;

  logic        clr, prt, sub_ok;
  logic [33:0] rem_sh;
  logic [32:0] rem_diff;
  logic [9:0]  quo_nx, ratio_nx;
  logic [3:0]  sel_nx;
  logic [31:0] word_nx;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign clr = op_valid && (n == 4'd8);
  assign prt = op_valid && (n == 4'd9);

  always_comb begin
    ins_reads_d  = sat_inc(ins_reads_q,  op_valid && (n == 4'd2));
    dat_reads_d  = sat_inc(dat_reads_q,  op_valid && (n == 4'd0));
    dat_writes_d = sat_inc(dat_writes_q, op_valid && (n == 4'd1));
    ins_hits_d   = sat_inc(ins_hits_q,   ins_hit);
    ins_misses_d = sat_inc(ins_misses_q, ins_miss);
    dat_hits_d   = sat_inc(dat_hits_q,   dat_hit);
    dat_misses_d = sat_inc(dat_misses_q, dat_miss);
    if (clr) begin
      ins_reads_d  = '0;
      dat_reads_d  = '0;
      dat_writes_d = '0;
      ins_hits_d   = '0;
      ins_misses_d = '0;
      dat_hits_d   = '0;
      dat_misses_d = '0;
    end
  end

  // Remainder stays below the denominator, so the difference always fits in 33 bits.
  always_comb begin
    rem_sh   = {div_rem_q, div_num_q[41]};
    sub_ok   = rem_sh >= {1'b0, div_den_q};
    rem_diff = rem_sh[32:0] - div_den_q;
    quo_nx   = {div_quo_q, sub_ok};
    ratio_nx = (div_den_q == '0) ? 10'd0 : quo_nx;
  end

  always_comb begin
    sel_nx = rpt_sel_q + 4'd1;
    case (sel_nx)
      4'd1:    word_nx = snap_ins_hits_q;
      4'd2:    word_nx = snap_ins_misses_q;
      4'd3:    word_nx = {22'd0, ins_ratio_q};
      4'd4:    word_nx = snap_dat_reads_q;
      4'd5:    word_nx = snap_dat_writes_q;
      4'd6:    word_nx = snap_dat_hits_q;
      4'd7:    word_nx = snap_dat_misses_q;
      4'd8:    word_nx = {22'd0, dat_ratio_q};
      default: word_nx = '0;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    busy_d            = busy_q;
    rpt_valid_d       = rpt_valid_q;
    rpt_sel_d         = rpt_sel_q;
    rpt_data_d        = rpt_data_q;
    rpt_last_d        = rpt_last_q;
    snap_ins_reads_d  = snap_ins_reads_q;
    snap_dat_reads_d  = snap_dat_reads_q;
    snap_dat_writes_d = snap_dat_writes_q;
    snap_ins_hits_d   = snap_ins_hits_q;
    snap_ins_misses_d = snap_ins_misses_q;
    snap_dat_hits_d   = snap_dat_hits_q;
    snap_dat_misses_d = snap_dat_misses_q;
    ins_ratio_d       = ins_ratio_q;
    dat_ratio_d       = dat_ratio_q;
    div_num_d         = div_num_q;
    div_den_d         = div_den_q;
    div_rem_d         = div_rem_q;
    div_quo_d         = div_quo_q;
    div_cnt_d         = div_cnt_q;
    if ((state_q == DIV_I) || (state_q == DIV_D)) begin
      div_num_d = {div_num_q[40:0], 1'b0};
      div_rem_d = sub_ok ? rem_diff : rem_sh[32:0];
      div_quo_d = quo_nx[8:0];
      div_cnt_d = div_cnt_q + 6'd1;
    end
    case (state_q)
      IDLE: if (prt) begin
        state_d           = DIV_I;
        busy_d            = 1'b1;
        snap_ins_reads_d  = ins_reads_d;
        snap_dat_reads_d  = dat_reads_d;
        snap_dat_writes_d = dat_writes_d;
        snap_ins_hits_d   = ins_hits_d;
        snap_ins_misses_d = ins_misses_d;
        snap_dat_hits_d   = dat_hits_d;
        snap_dat_misses_d = dat_misses_d;
        div_num_d         = {10'd0, ins_hits_d} * 42'd1000;
        div_den_d         = {1'b0, ins_hits_d} + {1'b0, ins_misses_d};
        div_rem_d         = '0;
        div_quo_d         = '0;
        div_cnt_d         = '0;
      end
      DIV_I: if (div_cnt_q == 6'd41) begin
        state_d     = DIV_D;
        ins_ratio_d = ratio_nx;
        div_num_d   = {10'd0, snap_dat_hits_q} * 42'd1000;
        div_den_d   = {1'b0, snap_dat_hits_q} + {1'b0, snap_dat_misses_q};
        div_rem_d   = '0;
        div_quo_d   = '0;
        div_cnt_d   = '0;
      end
      DIV_D: if (div_cnt_q == 6'd41) begin
        state_d     = SEND;
        dat_ratio_d = ratio_nx;
        rpt_valid_d = 1'b1;
        rpt_sel_d   = 4'd0;
        rpt_data_d  = snap_ins_reads_q;
        rpt_last_d  = 1'b0;
      end
      SEND: if (rpt_valid_q && rpt_ready) begin
        if (rpt_last_q) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          rpt_valid_d = 1'b0;
          rpt_sel_d   = 4'd0;
          rpt_data_d  = '0;
          rpt_last_d  = 1'b0;
        end else begin
          rpt_sel_d  = sel_nx;
          rpt_data_d = word_nx;
          rpt_last_d = (sel_nx == 4'd8);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      rpt_valid_q       <= 1'b0;
      rpt_sel_q         <= '0;
      rpt_data_q        <= '0;
      rpt_last_q        <= 1'b0;
      ins_reads_q       <= '0;
      dat_reads_q       <= '0;
      dat_writes_q      <= '0;
      ins_hits_q        <= '0;
      ins_misses_q      <= '0;
      dat_hits_q        <= '0;
      dat_misses_q      <= '0;
      snap_ins_reads_q  <= '0;
      snap_dat_reads_q  <= '0;
      snap_dat_writes_q <= '0;
      snap_ins_hits_q   <= '0;
      snap_ins_misses_q <= '0;
      snap_dat_hits_q   <= '0;
      snap_dat_misses_q <= '0;
      ins_ratio_q       <= '0;
      dat_ratio_q       <= '0;
      div_num_q         <= '0;
      div_den_q         <= '0;
      div_rem_q         <= '0;
      div_quo_q         <= '0;
      div_cnt_q         <= '0;
    end else begin
      state_q           <= state_d;
      busy_q            <= busy_d;
      rpt_valid_q       <= rpt_valid_d;
      rpt_sel_q         <= rpt_sel_d;
      rpt_data_q        <= rpt_data_d;
      rpt_last_q        <= rpt_last_d;
      ins_reads_q       <= ins_reads_d;
      dat_reads_q       <= dat_reads_d;
      dat_writes_q      <= dat_writes_d;
      ins_hits_q        <= ins_hits_d;
      ins_misses_q      <= ins_misses_d;
      dat_hits_q        <= dat_hits_d;
      dat_misses_q      <= dat_misses_d;
      snap_ins_reads_q  <= snap_ins_reads_d;
      snap_dat_reads_q  <= snap_dat_reads_d;
      snap_dat_writes_q <= snap_dat_writes_d;
      snap_ins_hits_q   <= snap_ins_hits_d;
      snap_ins_misses_q <= snap_ins_misses_d;
      snap_dat_hits_q   <= snap_dat_hits_d;
      snap_dat_misses_q <= snap_dat_misses_d;
      ins_ratio_q       <= ins_ratio_d;
      dat_ratio_q       <= dat_ratio_d;
      div_num_q         <= div_num_d;
      div_den_q         <= div_den_d;
      div_rem_q         <= div_rem_d;
      div_quo_q         <= div_quo_d;
      div_cnt_q         <= div_cnt_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_sel   = rpt_sel_q;
  assign rpt_data  = rpt_data_q;
  assign rpt_last  = rpt_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cache_stats.sv
// Directed bench for cache_stats: hand-computed report words, latency, backpressure, clear, saturation, reset.
module tb_cache_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  n = 4'd0;
  logic        ins_hit = 1'b0, ins_miss = 1'b0, dat_hit = 1'b0, dat_miss = 1'b0;
  logic        rpt_valid, rpt_ready = 1'b1, rpt_last, busy;
  logic [3:0]  rpt_sel;
  logic [31:0] rpt_data;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_w [9];

  cache_stats dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .n(n),
    .ins_hit(ins_hit), .ins_miss(ins_miss), .dat_hit(dat_hit), .dat_miss(dat_miss),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_sel(rpt_sel),
    .rpt_data(rpt_data), .rpt_last(rpt_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic ov, input logic [3:0] cmd, input logic ih, input logic im,
                    input logic dh, input logic dm);
    op_valid = ov; n = cmd; ins_hit = ih; ins_miss = im; dat_hit = dh; dat_miss = dm;
    step();
    op_valid = 1'b0; n = 4'd0; ins_hit = 1'b0; ins_miss = 1'b0; dat_hit = 1'b0; dat_miss = 1'b0;
  endtask

  // Issue a print and wait for the first word; optional extra print/clear at a cycle offset.
  task automatic do_print(input int prt_at, input int clr_at);
    int cnt;
    op_valid = 1'b1; n = 4'd9;
    step();
    op_valid = 1'b0;
    check_val("busy_rise", {31'd0, busy}, 32'd1);
    cnt = 1;
    while (!rpt_valid && cnt < 200) begin
      op_valid = (cnt == prt_at) || (cnt == clr_at);
      n = (cnt == clr_at) ? 4'd8 : 4'd9;
      step();
      op_valid = 1'b0;
      cnt++;
    end
    check_val("first_valid_latency", cnt, 32'd85);
  endtask

  task automatic collect(input int bp_idx, input int bp_len, input int stop_at);
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("w%0d_valid", i), {31'd0, rpt_valid}, 32'd1);
      check_val($sformatf("w%0d_sel", i), {28'd0, rpt_sel}, i);
      check_val($sformatf("w%0d_data", i), rpt_data, exp_w[i]);
      check_val($sformatf("w%0d_last", i), {31'd0, rpt_last}, (i == 8) ? 32'd1 : 32'd0);
      if (i == stop_at) return;
      if (i == bp_idx) begin
        rpt_ready = 1'b0;
        for (int k = 0; k < bp_len; k++) begin
          step();
          check_val("bp_valid", {31'd0, rpt_valid}, 32'd1);
          check_val("bp_sel", {28'd0, rpt_sel}, i);
          check_val("bp_data", rpt_data, exp_w[i]);
        end
        rpt_ready = 1'b1;
      end
      step();
    end
    check_val("end_valid", {31'd0, rpt_valid}, 32'd0);
    check_val("end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    check_val("rst_valid", {31'd0, rpt_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_sel", {28'd0, rpt_sel}, 32'd0);
    check_val("rst_data", rpt_data, 32'd0);
    check_val("rst_last", {31'd0, rpt_last}, 32'd0);
    rst = 1'b0;
    step();

    // Activity that a mid-run reset must wipe out
    ev(1, 4'd2, 1, 0, 1, 0);
    ev(1, 4'd0, 0, 1, 0, 1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // 4 fetches, 3 hits + 1 miss; backpressure on word 3
    ev(1, 4'd2, 1, 0, 0, 0);
    ev(1, 4'd2, 1, 0, 0, 0);
    ev(1, 4'd2, 0, 1, 0, 0);
    ev(1, 4'd2, 1, 0, 0, 0);
    exp_w = '{32'd4, 32'd3, 32'd1, 32'd750, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(3, 5, 99);

    // Data mix: 2 reads, 1 write, 1 hit, 2 misses -> 1000/3 floors to 333
    ev(1, 4'd0, 0, 0, 1, 0);
    ev(1, 4'd0, 0, 0, 0, 1);
    ev(1, 4'd1, 0, 0, 0, 1);
    exp_w = '{32'd4, 32'd3, 32'd1, 32'd750, 32'd2, 32'd1, 32'd1, 32'd2, 32'd333};
    do_print(0, 0);
    collect(-1, 0, 99);

    // Clear coincident with events: all events discarded, zero denominators give ratio 0
    ev(1, 4'd8, 1, 1, 1, 1);
    exp_w = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(-1, 0, 99);

    // Print while busy (DIV_I) ignored; clear during DIV_D leaves snapshot intact
    ev(1, 4'd2, 1, 0, 0, 0);
    ev(1, 4'd2, 0, 1, 0, 0);
    ev(1, 4'd0, 0, 0, 1, 0);
    exp_w = '{32'd2, 32'd1, 32'd1, 32'd500, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1000};
    do_print(10, 50);
    collect(-1, 0, 99);
    exp_w = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(-1, 0, 99);

    // Reset while word 5 is presented
    ev(1, 4'd2, 1, 0, 0, 0);
    ev(1, 4'd2, 1, 0, 0, 0);
    ev(1, 4'd2, 1, 0, 0, 0);
    exp_w = '{32'd3, 32'd3, 32'd0, 32'd1000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(-1, 0, 5);
    rst = 1'b1;
    #1;
    check_val("midrst_valid", {31'd0, rpt_valid}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();
    exp_w = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(-1, 0, 99);

    // Saturation: hits 0xFFFFFFFE + 3 pulses, one pulse also carrying a miss
    // ratio = floor(0xFFFFFFFF*1000 / 2^32) = 999
    force dut.ins_hits_q = 32'hFFFF_FFFE;
    step();
    release dut.ins_hits_q;
    ev(0, 4'd0, 1, 0, 0, 0);
    ev(0, 4'd0, 1, 0, 0, 0);
    ev(0, 4'd0, 1, 1, 0, 0);
    exp_w = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'd999, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_print(0, 0);
    collect(-1, 0, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
